// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO router: FSM states, region codes,
// the error read pattern and the bit layout of a trace entry.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [3:0] REGION_VMEM   = 4'hc;
  localparam logic [3:0] REGION_TIMER  = 4'hd;
  localparam logic [3:0] REGION_KBD    = 4'he;
  localparam logic [3:0] REGION_LOADER = 4'hf;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // Device index is carried as 3 bits so up to 8 channels fit a trace entry.
  localparam int IDX_W = 3;

  localparam int TR_W        = 64;
  localparam int TR_ERR_BIT  = 63;
  localparam int TR_WE_BIT   = 62;
  localparam int TR_IDX_LSB  = 59;
  localparam int TR_ADDR_LSB = 32;
  localparam int TR_ADDR_W   = 27;
  localparam int TR_DATA_LSB = 0;
  localparam int TR_DATA_W   = 32;

  function automatic logic [TR_W-1:0] trace_pack(
    input logic                 err,
    input logic                 we,
    input logic [IDX_W-1:0]     idx,
    input logic [TR_ADDR_W-1:0] addr,
    input logic [TR_DATA_W-1:0] data
  );
    logic [TR_W-1:0] entry;
    entry                              = '0;
    entry[TR_ERR_BIT]                  = err;
    entry[TR_WE_BIT]                   = we;
    entry[TR_IDX_LSB +: IDX_W]         = idx;
    entry[TR_ADDR_LSB +: TR_ADDR_W]    = addr;
    entry[TR_DATA_LSB +: TR_DATA_W]    = data;
    return entry;
  endfunction

endpackage

// File: rtl/mmio_trace_buf.sv
// Circular trace buffer: one synchronous write port, an asynchronous read
// port and a fill count that saturates at DEPTH. DEPTH must be a power of 2.
module mmio_trace_buf #(
  parameter  int DEPTH = 16,
  parameter  int W     = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             ui_clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [W-1:0]     rd_data,
  output logic [IDX_W:0]   count
);

  localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W:0]   count_q;

  // NOTE: storage is deliberately not reset; count_q says which entries are valid.
  always_ff @(posedge ui_clk) begin
    if (wr_en && rst) begin
      mem_q[ptr_q] <= wr_data;
    end
  end

  // NOTE: rst is synchronous and active-low, so it is sampled inside the clocked block.
  always_ff @(posedge ui_clk) begin
    if (!rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (wr_en) begin
      ptr_q <= ptr_q + 1'b1;
      if (count_q != CNT_FULL) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign rd_data = mem_q[rd_idx];
  assign count   = count_q;

endmodule

// File: rtl/mmio_router.sv
// Routes single CPU MMIO accesses to one of NUM_DEV devices by region code,
// with ack timeout and error capture. Optional trace: MMIO_ROUTER_TRACE_EN.
module mmio_router
  import mmio_pkg::*;
#(
  parameter  int                  NUM_DEV     = 4,
  parameter  int                  ADDR_W      = 30,
  parameter  int                  DATA_W      = 32,
  parameter  logic [4*NUM_DEV-1:0] REGION_MAP = {REGION_LOADER, REGION_KBD, REGION_TIMER, REGION_VMEM},
  parameter  int                  TIMEOUT     = 255,
  parameter  logic [DATA_W-1:0]   ERR_DATA    = DATA_W'(ERR_DATA_DEFAULT),
  parameter  int                  TRACE_DEPTH = 16,
  localparam int                  TIDX_W      = $clog2(TRACE_DEPTH)
) (
  input  logic                      ui_clk,
  input  logic                      rst,
  input  logic                      cpu_rd,
  input  logic                      cpu_wr,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  input  logic [3:0]                cpu_be,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_stall,
  output logic [NUM_DEV-1:0]        dev_req,
  output logic                      dev_we,
  output logic [ADDR_W-1:0]         dev_addr,
  output logic [DATA_W-1:0]         dev_wdata,
  output logic [3:0]                dev_be,
  input  logic [NUM_DEV-1:0]        dev_ack,
  input  logic [NUM_DEV*DATA_W-1:0] dev_rdata,
  output logic                      err_sticky,
  output logic [ADDR_W-1:0]         err_addr,
  input  logic [TIDX_W-1:0]         trace_idx,
  output logic [63:0]               trace_data,
  output logic [TIDX_W:0]           trace_count
);

  state_e              state_q;
  logic [NUM_DEV-1:0]  dev_req_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          be_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [7:0]          wait_q;
  logic [7:0]          wait_d;
  logic                err_sticky_q;
  logic [ADDR_W-1:0]   err_addr_q;

  logic                req_valid;
  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic [NUM_DEV-1:0]  hit_onehot;
  logic                ack_sel;
  logic [DATA_W-1:0]   rdata_sel;

  assign req_valid = cpu_rd | cpu_wr;
  assign wait_d    = wait_q + 8'd1;

  // Descending scan so the lowest matching channel overwrites any higher one.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if (cpu_addr[ADDR_W-1 -: 4] == REGION_MAP[4*i +: 4]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    hit_onehot = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      hit_onehot[i] = hit && (hit_idx == IDX_W'(i));
    end
  end

  // Only the latched channel's ack and data are visible to the FSM.
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        ack_sel   = dev_ack[i];
        rdata_sel = dev_rdata[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    cpu_stall = 1'b0;
    case (state_q)
      ST_IDLE: cpu_stall = req_valid && hit;
      ST_REQ:  cpu_stall = 1'b1;
      default: cpu_stall = 1'b0;
    endcase
  end

  // NOTE: all state and registered outputs update with non-blocking assignments.
  always_ff @(posedge ui_clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      dev_req_q    <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      idx_q        <= '0;
      rdata_q      <= '0;
      wait_q       <= '0;
      err_sticky_q <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && hit) begin
            we_q      <= cpu_wr;
            addr_q    <= cpu_addr;
            wdata_q   <= cpu_wdata;
            be_q      <= cpu_be;
            idx_q     <= hit_idx;
            dev_req_q <= hit_onehot;
            wait_q    <= '0;
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack_sel) begin
            dev_req_q <= '0;
            rdata_q   <= we_q ? '0 : rdata_sel;
            state_q   <= ST_DONE;
          end else if (wait_d == 8'(TIMEOUT)) begin
            dev_req_q    <= '0;
            rdata_q      <= ERR_DATA;
            wait_q       <= wait_d;
            err_sticky_q <= 1'b1;
            err_addr_q   <= addr_q;
            state_q      <= ST_ERR;
          end else begin
            wait_q <= wait_d;
          end
        end
        ST_DONE, ST_ERR: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata  = rdata_q;
  assign dev_req    = dev_req_q;
  assign dev_we     = we_q;
  assign dev_addr   = addr_q;
  assign dev_wdata  = wdata_q;
  assign dev_be     = be_q;
  assign err_sticky = err_sticky_q;
  assign err_addr   = err_addr_q;

`ifdef MMIO_ROUTER_TRACE_EN
  logic            trace_we;
  logic [TR_W-1:0] trace_entry;

  // Writes log the store data, reads log what was returned to the CPU.
  assign trace_we    = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign trace_entry = trace_pack(state_q == ST_ERR, we_q, idx_q,
                                  TR_ADDR_W'(addr_q),
                                  TR_DATA_W'(we_q ? wdata_q : rdata_q));

  mmio_trace_buf #(
    .DEPTH (TRACE_DEPTH),
    .W     (TR_W)
  ) u_trace_buf (
    .ui_clk  (ui_clk),
    .rst     (rst),
    .wr_en   (trace_we),
    .wr_data (trace_entry),
    .rd_idx  (trace_idx),
    .rd_data (trace_data),
    .count   (trace_count)
  );
`else
  logic trace_idx_unused;
  assign trace_idx_unused = ^trace_idx;
  assign trace_data       = '0;
  assign trace_count      = '0;
`endif

endmodule

// File: tb/tb_mmio_router.sv
// Directed bench for mmio_router: decode, ack handshake, timeout/error,
// reset during a request and (when MMIO_ROUTER_TRACE_EN is set) the trace ring.
module tb_mmio_router;

  logic          ui_clk = 1'b0;
  logic          rst;
  logic          cpu_rd;
  logic          cpu_wr;
  logic [29:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [3:0]    cpu_be;
  logic [31:0]   cpu_rdata;
  logic          cpu_stall;
  logic [3:0]    dev_req;
  logic          dev_we;
  logic [29:0]   dev_addr;
  logic [31:0]   dev_wdata;
  logic [3:0]    dev_be;
  logic [3:0]    dev_ack;
  logic [127:0]  dev_rdata;
  logic          err_sticky;
  logic [29:0]   err_addr;
  logic [3:0]    trace_idx;
  logic [63:0]   trace_data;
  logic [4:0]    trace_count;

  int n_checks = 0;
  int n_errors = 0;

  mmio_router #(
    .NUM_DEV     (4),
    .TIMEOUT     (8),
    .TRACE_DEPTH (16)
  ) dut (
    .ui_clk      (ui_clk),
    .rst         (rst),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_be      (cpu_be),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .dev_req     (dev_req),
    .dev_we      (dev_we),
    .dev_addr    (dev_addr),
    .dev_wdata   (dev_wdata),
    .dev_be      (dev_be),
    .dev_ack     (dev_ack),
    .dev_rdata   (dev_rdata),
    .err_sticky  (err_sticky),
    .err_addr    (err_addr),
    .trace_idx   (trace_idx),
    .trace_data  (trace_data),
    .trace_count (trace_count)
  );

  always #5 ui_clk = ~ui_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  // One CPU access. ack_at is the REQ cycle (1-based) in which the selected
  // device acks, 0 for never; a stray ack on another channel is driven in
  // REQ cycle 2 whenever the real ack is not due then.
  task automatic access(input string tag, input logic wr, input logic [29:0] addr,
                        input logic [31:0] data, input int ack_at, input int exp_idx,
                        input int exp_req_cycles, input logic [31:0] exp_rdata);
    logic [3:0] oh;
    int n;
    oh        = 4'b0001 << exp_idx;
    cpu_rd    = ~wr;
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_wdata = data;
    cpu_be    = 4'hf;
    dev_rdata = '0;
    dev_rdata[exp_idx*32 +: 32] = data;
    #1;
    check({tag, ":stall_idle"}, 64'(cpu_stall), 64'd1);
    n = 0;
    tick();
    while (cpu_stall === 1'b1 && n < 40) begin
      n++;
      check({tag, ":dev_req"}, 64'(dev_req), 64'(oh));
      if (n == 1) begin
        check({tag, ":dev_we"}, 64'(dev_we), 64'(wr));
        check({tag, ":dev_addr"}, 64'(dev_addr), 64'(addr));
        check({tag, ":dev_be"}, 64'(dev_be), 64'hf);
        if (wr) check({tag, ":dev_wdata"}, 64'(dev_wdata), 64'(data));
      end
      if (n == ack_at)  dev_ack = oh;
      else if (n == 2)  dev_ack = 4'b0001 << ((exp_idx + 1) % 4);
      else              dev_ack = '0;
      tick();
      dev_ack = '0;
    end
    check({tag, ":req_cycles"}, 64'(n), 64'(exp_req_cycles));
    check({tag, ":done_req"}, 64'(dev_req), 64'd0);
    check({tag, ":rdata"}, 64'(cpu_rdata), 64'(exp_rdata));
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    tick();
    check({tag, ":stall_after"}, 64'(cpu_stall), 64'd0);
  endtask

  initial begin
    rst       = 1'b0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_be    = '0;
    dev_ack   = '0;
    dev_rdata = '0;
    trace_idx = '0;
    tick();
    tick();
    check("rst_dev_req", 64'(dev_req), 64'd0);
    check("rst_rdata", 64'(cpu_rdata), 64'd0);
    check("rst_err_sticky", 64'(err_sticky), 64'd0);
    check("rst_err_addr", 64'(err_addr), 64'd0);
    check("rst_stall", 64'(cpu_stall), 64'd0);
    check("rst_trace_count", 64'(trace_count), 64'd0);
    rst = 1'b1;
    tick();

    // Unmapped address: no stall, no device request.
    cpu_rd   = 1'b1;
    cpu_addr = 30'h0000_0100;
    #1;
    check("pass_stall", 64'(cpu_stall), 64'd0);
    tick();
    check("pass_dev_req", 64'(dev_req), 64'd0);
    check("pass_stall2", 64'(cpu_stall), 64'd0);
    cpu_rd = 1'b0;
    tick();

    access("wr_dev0", 1'b1, 30'h3000_0010, 32'h0000_0041, 3, 0, 3, 32'h0);
    access("rd_dev1", 1'b0, 30'h3400_0020, 32'h0000_1234, 1, 1, 1, 32'h0000_1234);
    check("no_err_yet", 64'(err_sticky), 64'd0);

    access("to_dev2", 1'b0, 30'h3800_0040, 32'h0, 0, 2, 8, 32'hDEAD_BEEF);
    check("to_sticky", 64'(err_sticky), 64'd1);
    check("to_err_addr", 64'(err_addr), 64'h3800_0040);

    access("rd_dev3", 1'b0, 30'h3C00_0004, 32'h5555_AAAA, 2, 3, 2, 32'h5555_AAAA);
    check("sticky_kept", 64'(err_sticky), 64'd1);
    check("err_addr_kept", 64'(err_addr), 64'h3800_0040);

    access("to_dev3", 1'b1, 30'h3C00_0008, 32'h0000_0077, 0, 3, 8, 32'hDEAD_BEEF);
    check("err_addr_new", 64'(err_addr), 64'h3C00_0008);

    // Reset while a request is outstanding, then a late ack.
    cpu_wr   = 1'b1;
    cpu_addr = 30'h3C00_000C;
    tick();
    check("rr_dev_req", 64'(dev_req), 64'h8);
    rst    = 1'b0;
    cpu_wr = 1'b0;
    tick();
    check("rr_req_dropped", 64'(dev_req), 64'd0);
    rst     = 1'b1;
    dev_ack = 4'b1000;
    tick();
    dev_ack = '0;
    check("rr_late_req", 64'(dev_req), 64'd0);
    check("rr_late_stall", 64'(cpu_stall), 64'd0);
    check("rr_sticky_clr", 64'(err_sticky), 64'd0);
    check("rr_err_addr_clr", 64'(err_addr), 64'd0);
    tick();
    check("rr_no_done", 64'(cpu_rdata), 64'd0);
    check("rr_trace_count", 64'(trace_count), 64'd0);

    // 18 accesses to exercise the trace ring wrap.
    for (int k = 1; k <= 17; k++) begin
      access("trace_wr", 1'b1, 30'h3000_0000 + 30'(k), 32'(k), 1, 0, 1, 32'h0);
    end
    access("trace_rd18", 1'b0, 30'h3400_0012, 32'hABCD_0012, 1, 1, 1, 32'hABCD_0012);

`ifdef MMIO_ROUTER_TRACE_EN
    check("tr_count", 64'(trace_count), 64'd16);
    trace_idx = 4'd0;
    #1;
    check("tr_entry0", trace_data, 64'h4000_0011_0000_0011);
    trace_idx = 4'd1;
    #1;
    check("tr_entry1", trace_data, 64'h0C00_0012_ABCD_0012);
    trace_idx = 4'd2;
    #1;
    check("tr_entry2", trace_data, 64'h4000_0003_0000_0003);
`else
    check("tr_count_off", 64'(trace_count), 64'd0);
    trace_idx = 4'd1;
    #1;
    check("tr_data_off", trace_data, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
